// File: rtl/panel_test_pkg.sv
// Shared types and default geometry for the panel-test pattern path.
package panel_test_pkg;

  typedef enum logic [1:0] {
    SOLID   = 2'd0,
    COLBAR  = 2'd1,
    CHECKER = 2'd2,
    RAMP    = 2'd3
  } pattern_mode_t;

  localparam int unsigned PT_LANES            = 30;
  localparam int unsigned PT_WORDS_PER_COLUMN = 768;
  localparam int unsigned PT_COLUMNS          = 128;

endpackage

// File: rtl/panel_pattern_word.sv
// Combinational test-pattern generator: (mode, word, column) -> one lane word.
module panel_pattern_word
  import panel_test_pkg::*;
#(
  parameter int unsigned LANES = PT_LANES
) (
  input  pattern_mode_t    mode,
  input  logic [3:0]       w_lo,
  input  logic [3:0]       c_lo,
  output logic [LANES-1:0] word
);

  always_comb begin
    word = '0;
    unique case (mode)
      SOLID:   word = '1;
      COLBAR:  word = (c_lo == 4'd0) ? '1 : '0;
      CHECKER: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          word[l] = l[0] ^ w_lo[0] ^ c_lo[0];
        end
      end
      RAMP:    word = (w_lo < c_lo) ? '1 : '0;
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/panel_pattern_source.sv
// Test-pattern framebuffer feeder: tracks column/word position and serves
// one pattern word per request, one cycle after the request.
module panel_pattern_source
  import panel_test_pkg::*;
#(
  parameter int unsigned LANES            = PT_LANES,
  parameter int unsigned WORDS_PER_COLUMN = PT_WORDS_PER_COLUMN,
  parameter int unsigned COLUMNS          = PT_COLUMNS
) (
  input  logic                       clk_hse,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic                       position_sync,
  input  logic                       column_ready,
  input  logic                       data_req,
  output logic [LANES-1:0]           framebuffer_dat,
  output logic                       data_valid,
  output logic [$clog2(COLUMNS)-1:0] column_index,
  output logic                       overrun
);

  localparam int unsigned CW = $clog2(COLUMNS);
  localparam int unsigned WW = $clog2(WORDS_PER_COLUMN + 1);
  localparam logic [WW-1:0] WORD_LIMIT = WW'(WORDS_PER_COLUMN);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLUMNS - 1);

  pattern_mode_t    mode_q;
  logic             enable_q;
  logic [WW-1:0]    word_cnt;

  logic             col_event;
  logic             word_sat;
  logic [CW-1:0]    next_col;

  pattern_mode_t    eff_mode;
  logic             eff_enable;
  logic [3:0]       eff_w;
  logic [3:0]       eff_c;
  logic [LANES-1:0] pattern;
  logic [LANES-1:0] served;

  assign col_event = position_sync | column_ready;
  assign word_sat  = (word_cnt == WORD_LIMIT);
  assign next_col  = (column_index == COL_LAST) ? '0 : column_index + CW'(1);

  // A request coinciding with a column boundary is word 0 of the new column,
  // so the pattern inputs bypass the latches and take the incoming values.
  always_comb begin
    eff_mode   = mode_q;
    eff_enable = enable_q;
    eff_w      = word_cnt[3:0];
    eff_c      = column_index[3:0];
    if (col_event) begin
      eff_mode   = pattern_mode_t'(mode);
      eff_enable = enable;
      eff_w      = '0;
      eff_c      = position_sync ? '0 : next_col[3:0];
    end
    served = (eff_enable && (col_event || !word_sat)) ? pattern : '0;
  end

  panel_pattern_word #(
    .LANES (LANES)
  ) u_word (
    .mode (eff_mode),
    .w_lo (eff_w),
    .c_lo (eff_c),
    .word (pattern)
  );

  always_ff @(posedge clk_hse or posedge rst) begin
    if (rst) begin
      framebuffer_dat <= '0;
      data_valid      <= 1'b0;
      column_index    <= '0;
      overrun         <= 1'b0;
      word_cnt        <= '0;
      mode_q          <= SOLID;
      enable_q        <= 1'b1;
    end else begin
      data_valid <= data_req;
      if (data_req) begin
        framebuffer_dat <= served;
      end
      if (col_event) begin
        mode_q       <= pattern_mode_t'(mode);
        enable_q     <= enable;
        column_index <= position_sync ? '0 : next_col;
        overrun      <= 1'b0;
        word_cnt     <= data_req ? WW'(1) : '0;
      end else if (data_req) begin
        if (word_sat) begin
          overrun <= 1'b1;
        end else begin
          word_cnt <= word_cnt + WW'(1);
        end
      end
    end
  end

endmodule

// File: doc/panel_pattern_source.md
Name: panel_pattern_source

Overview:
- Upstream feeder for the panel-test path: generates the 30-lane framebuffer word stream consumed by driver_controller in place of real framebuffer data.
- Tracks column position within a turn (position_sync / column_ready) and word position within a column.
- Serves one word per request from a selectable test pattern, so drivers, cabling and LEDs can be exercised without the SoC framebuffer.

Parameters:
- LANES, 30, width of framebuffer word (one bit per driver SIN lane)
- WORDS_PER_COLUMN, 768, words requested per column (48 ch x 16 bit)
- COLUMNS, 128, columns per turn; column index wraps at this value

Ports:
- clk_hse  in  1  single block clock (66 MHz domain)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  0: all served words are zero
- mode  in  2  pattern select: 0 solid, 1 column bar, 2 checker, 3 ramp
- position_sync  in  1  one-cycle pulse: start of turn
- column_ready  in  1  one-cycle pulse: driver side starts a new column
- data_req  in  1  one-cycle request for next word
- framebuffer_dat  out  LANES  served word
- data_valid  out  1  framebuffer_dat valid this cycle
- column_index  out  $clog2(COLUMNS)  current column
- overrun  out  1  sticky: data_req beyond WORDS_PER_COLUMN in current column

Behaviour:
- Reset (async, rst=1): framebuffer_dat=0, data_valid=0, column_index=0, overrun=0, word counter=0, latched mode=0 (solid).
- Latency: data_req at cycle n -> data_valid=1 and word at cycle n+1. data_valid is 1 only in that cycle; framebuffer_dat holds its last value otherwise.
- Back-to-back data_req on consecutive cycles is supported: one word per cycle, word counter w increments per request.
- Word counter saturates at WORDS_PER_COLUMN; no wrap.
  - A request with w==WORDS_PER_COLUMN returns an all-zero word with data_valid=1 and sets overrun.
- column_ready:
  - w<=0, overrun<=0, column_index<=(column_index+1) mod COLUMNS.
  - mode and enable are sampled into latched registers at this point only, so there is no tearing mid-column.
- position_sync: column_index<=0, w<=0, overrun<=0; mode and enable are latched.
- position_sync and column_ready in the same cycle: position_sync wins, column_index=0.
- data_req coincident with column_ready or position_sync: the request is served as word 0 of the new column, using the newly latched mode. w becomes 1 after that cycle.
- Pattern for word w, column c, lane l (uses latched mode); result is ANDed with latched enable:
  - solid: all ones.
  - column bar: all ones if c[3:0]==0, else zero.
  - checker: bit l = l[0] ^ w[0] ^ c[0].
  - ramp: all lanes = (w[3:0] < c[3:0]).
- rst asserted mid-column: all state clears immediately. The first word after rst deassertion is word 0 of column 0, solid.

Decomposition:
- Package panel_test_pkg: pattern_mode_t enum (SOLID, COLBAR, CHECKER, RAMP), LANES and default geometry constants.
- Sub-module panel_pattern_word: combinational (mode, w, c) -> LANES-bit word.
- Top block holds counters, latches, request pipeline and overrun flag.

Test Plan:
- Reset, then position_sync, mode=0, enable=1, 3 data_req -> 3 words 0x3FFFFFFF, each one cycle after its req; column_index=0.
- mode=2, column_ready, 2 data_req -> word0=0x15555555 (c=1: bit l=~l[0]), word1=0x2AAAAAAA; column_index=1.
- Change mode mid-column -> pattern unchanged until next column_ready; new pattern from word 0 of the next column.
- Issue 769 data_req in one column -> request 769 returns 0 with data_valid=1, overrun=1. Next column_ready clears overrun.
- 128 column_ready pulses -> column_index wraps 127->0. position_sync coincident with column_ready -> column_index=0.
- Assert rst during a data_req burst -> outputs 0 asynchronously; after release, first req returns solid word 0x3FFFFFFF gated by enable.
